// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M MUL/DIV/DIVU/REM/REMU sequencer borrowing the core's shared ALU.
// Optional MULDIV_EARLY_OUT_EN ends MUL once the remaining multiplier bits are all zero.
module muldiv_seq #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        kill,
    output logic        ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        alu_req,
    output logic [3:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result
);
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_MUL, S_DIV_CMP, S_DIV_SUB, S_FIX, S_DONE} state_t;
    state_t r_state, w_next;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b, r_p, r_m, r_q, r_result;
    logic [5:0]  r_cnt;
    logic        r_negq, r_negr, r_ge;
    logic        w_illegal, w_div, w_signed, w_ge, w_last, w_mul_done;
    logic [31:0] w_rs, w_q_sh;
    assign w_illegal = ~r_op[2] & |r_op[1:0];
    assign w_div     = r_op[2];
    assign w_signed  = ~r_op[0];
    assign w_rs      = {r_p[30:0], r_q[31]};
    assign w_ge      = r_p[31] | alu_result[0];
    assign w_last    = r_cnt == 6'(ITER - 1);
    assign w_q_sh    = r_q >> 1;
`ifdef MULDIV_EARLY_OUT_EN
    assign w_mul_done = w_last || w_q_sh == 32'd0;
`else
    assign w_mul_done = w_last;
`endif
    assign ready     = r_state == S_IDLE;
    assign out_valid = r_state == S_DONE;
    assign result    = r_result;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        alu_req = 1'b0;
        alu_ctl = 4'd0;
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        case (r_state)
            S_IDLE:    w_next = start ? S_PREP : S_IDLE;
            S_PREP:    w_next = (w_illegal || (w_div && r_b == 32'd0)) ? S_DONE : w_div ? S_DIV_CMP : S_MUL;
            S_MUL: begin
                alu_req = 1'b1;
                alu_ctl = 4'b0010;
                alu_a   = r_p;
                alu_b   = r_m;
                w_next  = w_mul_done ? S_FIX : S_MUL;
            end
            S_DIV_CMP: begin
                alu_req = 1'b1;
                alu_ctl = 4'b1111;
                alu_a   = w_rs;
                alu_b   = r_m;
                w_next  = S_DIV_SUB;
            end
            // Visited even when no subtract is needed so division latency stays fixed
            S_DIV_SUB: begin
                alu_req = r_ge;
                alu_ctl = r_ge ? 4'b0110 : 4'd0;
                alu_a   = r_ge ? r_p : 32'd0;
                alu_b   = r_ge ? r_m : 32'd0;
                w_next  = w_last ? S_FIX : S_DIV_CMP;
            end
            S_FIX:     w_next = S_DONE;
            S_DONE:    w_next = out_ready ? S_IDLE : S_DONE;
            default:   w_next = S_IDLE;
        endcase
        if (kill) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= 3'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_p      <= 32'd0;
            r_m      <= 32'd0;
            r_q      <= 32'd0;
            r_result <= 32'd0;
            r_cnt    <= 6'd0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_ge     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= op;
                        r_a  <= in_a;
                        r_b  <= in_b;
                    end
                end
                S_PREP: begin
                    r_cnt <= 6'd0;
                    r_p   <= 32'd0;
                    if (w_illegal) r_result <= 32'd0;
                    else if (w_div && r_b == 32'd0) r_result <= r_op[1] ? r_a : 32'hFFFF_FFFF;
                    else if (!w_div) begin
                        r_m <= r_a;
                        r_q <= r_b;
                    end else begin
                        r_q    <= (w_signed && r_a[31]) ? -r_a : r_a;
                        r_m    <= (w_signed && r_b[31]) ? -r_b : r_b;
                        r_negq <= w_signed & (r_a[31] ^ r_b[31]);
                        r_negr <= w_signed & r_a[31];
                    end
                end
                S_MUL: begin
                    if (r_q[0]) r_p <= alu_result;
                    r_m   <= r_m << 1;
                    r_q   <= w_q_sh;
                    r_cnt <= r_cnt + 6'd1;
                end
                // The shifted-out remainder MSB is folded into ge, so R only needs 32 bits
                S_DIV_CMP: begin
                    r_p  <= w_rs;
                    r_q  <= {r_q[30:0], w_ge};
                    r_ge <= w_ge;
                end
                S_DIV_SUB: begin
                    if (r_ge) r_p <= alu_result;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FIX: r_result <= !w_div ? r_p : r_op[1] ? (r_negr ? -r_p : r_p) : (r_negq ? -r_q : r_q);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, kill = 1'b0, out_ready = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] in_a = 32'd0, in_b = 32'd0;
    logic        ready, out_valid, alu_req;
    logic [3:0]  alu_ctl;
    logic [31:0] result, alu_a, alu_b, alu_result;
    int          n_vec = 0, n_bad = 0;

    muldiv_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
        .kill(kill), .ready(ready), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .alu_req(alu_req), .alu_ctl(alu_ctl), .alu_a(alu_a),
        .alu_b(alu_b), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    // Shared core ALU: add, subtract, unsigned greater-or-equal
    always_comb
        alu_result = alu_ctl == 4'b0010 ? alu_a + alu_b :
                     alu_ctl == 4'b0110 ? alu_a - alu_b :
                     alu_ctl == 4'b1111 ? {31'd0, alu_a >= alu_b} : 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (o)
            3'd0: return a * b;
            3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            3'd7: return b == 0 ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int bitlen(input logic [31:0] b);
        int n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] b);
        if (o inside {3'd1, 3'd2, 3'd3}) return 2;
        if (o[2]) return b == 0 ? 2 : 67;
`ifdef MULDIV_EARLY_OUT_EN
        return 3 + bitlen(b);
`else
        return 35;
`endif
    endfunction

    // Protocol-level model: edges since acceptance, expected result, handshake
    logic        m_busy = 1'b0, armed = 1'b0;
    int          m_cnt = 0, m_lat = 0;
    logic [31:0] m_res = 32'd0;
    logic [2:0]  m_op = 3'd0;
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            armed  <= 1'b1;
        end else if (kill) m_busy <= 1'b0;
        else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_lat  <= ref_lat(op, in_b);
                m_res  <= ref_res(op, in_a, in_b);
                m_op   <= op;
            end
        end else if (m_cnt < m_lat) m_cnt <= m_cnt + 1;
        else if (out_ready) m_busy <= 1'b0;
    end

    int alu_n = 0;
    always @(negedge clk) begin
        if (armed && !reset) begin
            if (!m_busy) alu_n = 0;
            else if (alu_req) alu_n++;
            chk("ready", {31'd0, ready}, {31'd0, !m_busy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_busy && m_cnt == m_lat});
            if (m_busy && m_cnt == m_lat) begin
                chk("result", result, m_res);
                if (m_op == 3'd0) chk("mul alu cycles", 32'(alu_n), 32'(m_lat - 3));
            end
            if (!m_busy || m_cnt == m_lat) chk("alu_req idle", {31'd0, alu_req}, 32'd0);
            if (!alu_req) chk("alu bus quiet", {28'd0, alu_ctl} | alu_a | alu_b, 32'd0);
        end
    end

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input int exp_l, input string nm);
        int n;
        start = 1'b1; op = o; in_a = a; in_b = b; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1 n++;
        end
        chk({nm, " latency"}, 32'(n), 32'(exp_l));
        chk({nm, " value"}, result, exp_r);
        @(posedge clk); #1 chk({nm, " ready after"}, {31'd0, ready}, 32'd1);
    endtask

    logic [2:0]  ops [10] = '{3'd0, 3'd0, 3'd4, 3'd4, 3'd5, 3'd6, 3'd6, 3'd7, 3'd1, 3'd3};
    logic [31:0] held;
    logic        started;
    int          guard, n;

    initial begin
        chk("pin mul", ref_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("pin div", ref_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("pin rem", ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("pin divu", ref_res(3'd5, 32'd100, 32'd7), 32'd14);
        chk("pin lat div", 32'(ref_lat(3'd4, 32'd9)), 32'd67);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset ready", {31'd0, ready}, 32'd1);
        chk("reset result", result, 32'd0);
        chk("reset alu_req", {31'd0, alu_req}, 32'd0);

        run(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, "mul 7*-3");
        run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 67, "div -7/2");
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 67, "rem -7%2");
        run(3'd5, 32'd100, 32'd7, 32'd14, 67, "divu 100/7");
        run(3'd7, 32'd100, 32'd7, 32'd2, 67, "remu 100%7");
        run(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 2, "divu by 0");
        run(3'd6, 32'd5, 32'd0, 32'd5, 2, "rem by 0");
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 67, "div ovf");
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 67, "rem ovf");
        run(3'd2, 32'd5, 32'd6, 32'd0, 2, "illegal op");
`ifdef MULDIV_EARLY_OUT_EN
        run(3'd0, 32'd1234, 32'd3, 32'd3702, 5, "mul b=3");
`else
        run(3'd0, 32'd1234, 32'd3, 32'd3702, 35, "mul b=3");
`endif

        // kill sampled at edge 11 of a divide
        start = 1'b1; op = 3'd4; in_a = 32'd1000; in_b = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        chk("kill ready", {31'd0, ready}, 32'd1);
        chk("kill out_valid", {31'd0, out_valid}, 32'd0);
        repeat (80) @(posedge clk);
        #1;

        // result held while the consumer stalls
        out_ready = 1'b0;
        start = 1'b1; op = 3'd5; in_a = 32'd1000; in_b = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1 n++;
        end
        held = result;
        chk("stall value", held, 32'd142);
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall valid", {31'd0, out_valid}, 32'd1);
            chk("stall stable", result, held);
            chk("stall ready", {31'd0, ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1 chk("stall release", {31'd0, out_valid}, 32'd0);

        // reset mid-multiply
        start = 1'b1; op = 3'd0; in_a = 32'd5; in_b = 32'd9;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("mid reset ready", {31'd0, ready}, 32'd1);
        chk("mid reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid reset alu", {31'd0, alu_req} | {28'd0, alu_ctl} | alu_a | alu_b, 32'd0);
        chk("mid reset result", result, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 250; k++) begin
            op = ops[$urandom_range(0, 9)];
            in_a = $urandom_range(0, 7) == 0 ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: in_b = 32'd0;
                1: in_b = $urandom_range(1, 15);
                2: in_b = 32'hFFFF_FFFF;
                3: in_b = $urandom >> $urandom_range(0, 31);
                default: in_b = $urandom;
            endcase
            start = 1'b1;
            started = 1'b0;
            guard = 0;
            while (!(started && !m_busy) && guard < 400) begin
                @(posedge clk); #1 guard++;
                if (m_busy) started = 1'b1;
                start = started ? ($urandom_range(0, 3) == 0) : 1'b1;
                out_ready = $urandom_range(0, 2) != 0;
                kill = $urandom_range(0, 150) == 0;
            end
            chk("random op completes", {31'd0, started && !m_busy}, 32'd1);
        end
        start = 1'b0; kill = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end
endmodule
